// File: rtl/pos_search_if.sv
// Request/result bundle for pos_search_pipe: request channel, result channel
// and the saturating hit/miss statistics.
interface pos_search_if #(
  parameter int W     = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(W);

  logic             in_vld_i;
  logic             in_rdy_o;
  logic [W-1:0]     x_i;
  logic [LW-1:0]    pos_i;
  logic [1:0]       mode_i;
  logic             clr_i;
  logic [TAG_W-1:0] tag_i;

  logic             out_vld_o;
  logic             out_rdy_i;
  logic             any_o;
  logic [W-1:0]     y_o;
  logic [LW-1:0]    y_enc_o;
  logic [W-1:0]     rem_o;
  logic [TAG_W-1:0] tag_o;
  logic [CNT_W-1:0] hit_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  // master: request source / result sink
  modport master (
    output in_vld_i, x_i, pos_i, mode_i, clr_i, tag_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, any_o, y_o, y_enc_o, rem_o, tag_o,
           hit_cnt_o, miss_cnt_o
  );

  modport slave (
    input  in_vld_i, x_i, pos_i, mode_i, clr_i, tag_i, out_rdy_i,
    output in_rdy_o, out_vld_o, any_o, y_o, y_enc_o, rem_o, tag_o,
           hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/pos_search_pipe.sv
// Two-stage find-first-set from a start position with wrap/no-wrap and
// ascending/descending order; S1 rotates+masks, S2 encodes and clears.
module pos_search_pipe #(
  parameter int W     = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  pos_search_if.slave bus
);
  localparam int LW = $clog2(W);
  typedef logic [LW-1:0] idx_t;

  logic             s2_adv, in_rdy, in_acc, out_hs, s2_load;

  logic             s1_vld_q, s1_vld_d;
  logic [W-1:0]     s1_x_q, s1_x_d;
  logic [W-1:0]     s1_rot_q, s1_rot_d;
  idx_t             s1_pos_q, s1_pos_d;
  logic             s1_desc_q, s1_desc_d;
  logic             s1_clr_q, s1_clr_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_vld_q, s2_vld_d;
  logic             any_q, any_d;
  logic [W-1:0]     y_q, y_d;
  idx_t             enc_q, enc_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;

  idx_t             src, k;
  logic             keep;

  always_comb begin
    s2_adv  = ~s2_vld_q | bus.out_rdy_i;
    in_rdy  = ~s1_vld_q | s2_adv;
    in_acc  = bus.in_vld_i & in_rdy;
    out_hs  = s2_vld_q & bus.out_rdy_i;
    s2_load = s2_adv & s1_vld_q;
  end

  // Rotate so the search always runs from bit 0 upward; no-wrap modes mask
  // off the positions that would have wrapped past the end.
  always_comb begin
    s1_rot_d = '0;
    src      = '0;
    keep     = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (bus.mode_i[1]) src = bus.pos_i - idx_t'(i);
      else               src = bus.pos_i + idx_t'(i);
      if (!bus.mode_i[0])     keep = 1'b1;
      else if (bus.mode_i[1]) keep = (i <= int'(bus.pos_i));
      else                    keep = ((i + int'(bus.pos_i)) < W);
      s1_rot_d[i] = bus.x_i[src] & keep;
    end
    if (!in_acc) s1_rot_d = s1_rot_q;
  end

  always_comb begin
    s1_vld_d  = in_rdy ? bus.in_vld_i : s1_vld_q;
    s1_x_d    = in_acc ? bus.x_i       : s1_x_q;
    s1_pos_d  = in_acc ? bus.pos_i     : s1_pos_q;
    s1_desc_d = in_acc ? bus.mode_i[1] : s1_desc_q;
    s1_clr_d  = in_acc ? bus.clr_i     : s1_clr_q;
    s1_tag_d  = in_acc ? bus.tag_i     : s1_tag_q;
  end

  // Lowest set bit of the rotated vector is the offset from pos.
  always_comb begin
    k = '0;
    for (int i = W - 1; i >= 0; i--)
      if (s1_rot_q[i]) k = idx_t'(i);
    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    any_d    = any_q;
    y_d      = y_q;
    enc_d    = enc_q;
    rem_d    = rem_q;
    tag_d    = tag_q;
    if (s2_load) begin
      any_d = |s1_rot_q;
      enc_d = '0;
      if (any_d) enc_d = s1_desc_q ? (s1_pos_q - k) : (s1_pos_q + k);
      y_d   = any_d ? ({{(W-1){1'b0}}, 1'b1} << enc_d) : '0;
      rem_d = s1_clr_q ? (s1_x_q & ~y_d) : s1_x_q;
      tag_d = s1_tag_q;
    end
  end

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (out_hs && any_q && !(&hit_q))   hit_d  = hit_q + CNT_W'(1);
    if (out_hs && !any_q && !(&miss_q)) miss_d = miss_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // Payload flops are qualified by the valids and carry no reset.
  always_ff @(posedge clk) begin
    s1_x_q    <= s1_x_d;
    s1_rot_q  <= s1_rot_d;
    s1_pos_q  <= s1_pos_d;
    s1_desc_q <= s1_desc_d;
    s1_clr_q  <= s1_clr_d;
    s1_tag_q  <= s1_tag_d;
    any_q     <= any_d;
    y_q       <= y_d;
    enc_q     <= enc_d;
    rem_q     <= rem_d;
    tag_q     <= tag_d;
  end

  assign bus.in_rdy_o   = in_rdy;
  assign bus.out_vld_o  = s2_vld_q;
  assign bus.any_o      = any_q;
  assign bus.y_o        = y_q;
  assign bus.y_enc_o    = enc_q;
  assign bus.rem_o      = rem_q;
  assign bus.tag_o      = tag_q;
  assign bus.hit_cnt_o  = hit_q;
  assign bus.miss_cnt_o = miss_q;
endmodule

// File: tb/tb_pos_search_pipe.sv
// Directed bench for pos_search_pipe (W=8): search modes, stall/ordering,
// mid-flight reset and counter saturation on a CNT_W=2 instance.
module tb_pos_search_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_hit  = 0;
  int   exp_miss = 0;

  always #5 clk = ~clk;

  pos_search_if #(.W(8), .TAG_W(4), .CNT_W(16)) b1 ();
  pos_search_if #(.W(8), .TAG_W(4), .CNT_W(2))  b2 ();

  pos_search_pipe #(.W(8), .TAG_W(4), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(b1));
  pos_search_pipe #(.W(8), .TAG_W(4), .CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic drive1(input logic [7:0] x, input logic [2:0] pos, input logic [1:0] mode,
                        input logic clr, input logic [3:0] tag);
    b1.x_i = x; b1.pos_i = pos; b1.mode_i = mode; b1.clr_i = clr; b1.tag_i = tag;
  endtask

  task automatic run1(input string nm, input logic [7:0] x, input logic [2:0] pos,
                      input logic [1:0] mode, input logic clr, input logic [3:0] tag,
                      input logic any, input logic [7:0] y, input logic [2:0] enc,
                      input logic [7:0] rem);
    @(negedge clk);
    b1.out_rdy_i = 1'b1;
    b1.in_vld_i  = 1'b1;
    drive1(x, pos, mode, clr, tag);
    #1 chk({nm, "_rdy"}, b1.in_rdy_o, 1);
    @(negedge clk);
    b1.in_vld_i = 1'b0;
    #1 chk({nm, "_lat1"}, b1.out_vld_o, 0);
    @(negedge clk);
    #1;
    chk({nm, "_vld"}, b1.out_vld_o, 1);
    chk({nm, "_any"}, b1.any_o, any);
    chk({nm, "_y"},   b1.y_o, y);
    chk({nm, "_enc"}, b1.y_enc_o, enc);
    chk({nm, "_rem"}, b1.rem_o, rem);
    chk({nm, "_tag"}, b1.tag_o, tag);
    if (any) exp_hit++; else exp_miss++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_tag;
    int hs;
    logic stale;

    rst = 1'b1;
    b1.in_vld_i = 1'b0; b1.out_rdy_i = 1'b1; drive1(8'h0, 3'd0, 2'd0, 1'b0, 4'd0);
    b2.in_vld_i = 1'b0; b2.out_rdy_i = 1'b1;
    b2.x_i = 8'h0; b2.pos_i = 3'd0; b2.mode_i = 2'd0; b2.clr_i = 1'b0; b2.tag_i = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_outvld", b1.out_vld_o, 0);
    chk("rst_hit",    b1.hit_cnt_o, 0);
    chk("rst_miss",   b1.miss_cnt_o, 0);
    chk("rst_inrdy",  b1.in_rdy_o, 1);

    run1("m0p2",   8'h12, 3'd2, 2'd0, 1'b1, 4'd5,  1'b1, 8'h10, 3'd4, 8'h02);
    run1("m1p5",   8'h12, 3'd5, 2'd1, 1'b1, 4'd6,  1'b0, 8'h00, 3'd0, 8'h12);
    run1("m0p5",   8'h12, 3'd5, 2'd0, 1'b0, 4'd7,  1'b1, 8'h02, 3'd1, 8'h12);
    run1("m2p3",   8'h12, 3'd3, 2'd2, 1'b0, 4'd8,  1'b1, 8'h02, 3'd1, 8'h12);
    run1("m3p3",   8'h12, 3'd3, 2'd3, 1'b1, 4'd9,  1'b1, 8'h02, 3'd1, 8'h10);
    run1("m3p0",   8'h12, 3'd0, 2'd3, 1'b0, 4'd10, 1'b0, 8'h00, 3'd0, 8'h12);
    run1("m2p0",   8'h12, 3'd0, 2'd2, 1'b1, 4'd11, 1'b1, 8'h10, 3'd4, 8'h02);
    run1("zero",   8'h00, 3'd6, 2'd2, 1'b1, 4'd12, 1'b0, 8'h00, 3'd0, 8'h00);
    run1("m1p7",   8'h80, 3'd7, 2'd1, 1'b1, 4'd13, 1'b1, 8'h80, 3'd7, 8'h00);
    run1("m0wrap", 8'h01, 3'd7, 2'd0, 1'b1, 4'd14, 1'b1, 8'h01, 3'd0, 8'h00);
    @(negedge clk);
    #1;
    chk("cnt_hit",  b1.hit_cnt_o, exp_hit);
    chk("cnt_miss", b1.miss_cnt_o, exp_miss);

    // Stall: downstream blocked for 5 cycles while tags 1..4 are offered.
    @(negedge clk);
    b1.out_rdy_i = 1'b0;
    b1.in_vld_i  = 1'b1;
    drive1(8'h02, 3'd0, 2'd0, 1'b0, 4'd1);
    #1 chk("stall_rdy1", b1.in_rdy_o, 1);
    @(negedge clk);
    drive1(8'h04, 3'd0, 2'd0, 1'b0, 4'd2);
    #1 chk("stall_rdy2", b1.in_rdy_o, 1);
    @(negedge clk);
    drive1(8'h08, 3'd0, 2'd0, 1'b0, 4'd3);
    #1;
    chk("stall_rdy3", b1.in_rdy_o, 0);
    chk("stall_vld",  b1.out_vld_o, 1);
    chk("stall_tag",  b1.tag_o, 1);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("stall_hold_rdy", b1.in_rdy_o, 0);
      chk("stall_hold_tag", b1.tag_o, 1);
      chk("stall_hold_enc", b1.y_enc_o, 1);
      chk("stall_hold_y",   b1.y_o, 8'h02);
    end
    next_tag = 3;
    hs = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b1.out_rdy_i = 1'b1;
      if (next_tag > 4) b1.in_vld_i = 1'b0;
      else drive1(8'(1 << next_tag), 3'd0, 2'd0, 1'b0, 4'(next_tag));
      #1;
      if (b1.out_vld_o) begin
        hs++;
        chk("order_tag", b1.tag_o, hs);
        chk("order_enc", b1.y_enc_o, hs);
      end
      if (b1.in_vld_i && b1.in_rdy_o) next_tag++;
    end
    b1.in_vld_i = 1'b0;
    chk("stall_hs_count", hs, 4);
    exp_hit += 4;
    chk("stall_hit", b1.hit_cnt_o, exp_hit);

    // Reset while both stages hold data, with the consumer ready.
    @(negedge clk);
    b1.out_rdy_i = 1'b0;
    b1.in_vld_i  = 1'b1;
    drive1(8'h01, 3'd0, 2'd0, 1'b0, 4'd5);
    @(negedge clk);
    drive1(8'h01, 3'd0, 2'd0, 1'b0, 4'd6);
    @(negedge clk);
    b1.in_vld_i  = 1'b0;
    b1.out_rdy_i = 1'b1;
    rst = 1'b1;
    #1 chk("prerst_vld", b1.out_vld_o, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_vld",   b1.out_vld_o, 0);
    chk("midrst_hit",   b1.hit_cnt_o, 0);
    chk("midrst_miss",  b1.miss_cnt_o, 0);
    chk("midrst_inrdy", b1.in_rdy_o, 1);
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1 if (b1.out_vld_o) stale = 1'b1;
    end
    chk("midrst_stale", stale, 0);
    exp_hit = 0; exp_miss = 0;
    run1("postrst", 8'h40, 3'd1, 2'd0, 1'b1, 4'd15, 1'b1, 8'h40, 3'd6, 8'h00);

    // CNT_W=2 instance: five hits saturate at 3.
    @(negedge clk);
    b2.out_rdy_i = 1'b1;
    b2.in_vld_i  = 1'b1;
    b2.x_i = 8'h01; b2.pos_i = 3'd0; b2.mode_i = 2'd0; b2.clr_i = 1'b0; b2.tag_i = 4'd1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    b2.in_vld_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sat_hit",  b2.hit_cnt_o, 3);
    chk("sat_miss", b2.miss_cnt_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pos_search_pipe.md
POS_SEARCH_PIPE -- requirements
Module: pos_search_pipe

Interface
REQ-001 Parameter W, default 32: search vector width; power of two, >= 4.
REQ-002 Parameter TAG_W, default 4: width of the opaque tag carried with each transaction.
REQ-003 Parameter CNT_W, default 16: width of each saturating statistics counter.
REQ-004 One clock; reset is synchronous and active-high: ports clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-005 in_vld_i  input  1  request valid.
REQ-006 in_rdy_o  output  1  request accepted when in_vld_i & in_rdy_o at a rising edge of clk.
REQ-007 x_i  input  W  vector to search.
REQ-008 pos_i  input  $clog2(W)  start index.
REQ-009 mode_i  input  2  0 = ascending-wrap, 1 = ascending-nowrap, 2 = descending-wrap, 3 = descending-nowrap.
REQ-010 clr_i  input  1  clear the found bit in rem_o.
REQ-011 tag_i  input  TAG_W  passthrough tag.
REQ-012 out_vld_o  output  1  result valid.
REQ-013 out_rdy_i  input  1  result consumed when out_vld_o & out_rdy_i at a rising edge of clk.
REQ-014 any_o  output  1  a set bit was found.
REQ-015 y_o  output  W  one-hot mask of the found bit; 0 when nothing is found.
REQ-016 y_enc_o  output  $clog2(W)  index of the found bit; 0 when nothing is found.
REQ-017 rem_o  output  W  x & ~y when clr was set, else x.
REQ-018 tag_o  output  TAG_W  tag of the result.
REQ-019 hit_cnt_o, miss_cnt_o  output  CNT_W each  saturating counts of consumed results with any = 1 and any = 0.

Function
REQ-020 Search order:
  - mode 0: pos, pos+1, ..., W-1, 0, ..., pos-1.
  - mode 1: pos, pos+1, ..., W-1.
  - mode 2: pos, pos-1, ..., 0, W-1, ..., pos+1.
  - mode 3: pos, pos-1, ..., 0.
REQ-021 The found bit is the first index in search order where x is 1; any = 0 when no such index exists.
REQ-022 Two-stage pipeline:
  - S1 registers the accepted request, with the rotated/masked vector computed from x, pos and mode.
  - S2 registers the priority, encode and remainder results.
  - Latency from acceptance to out_vld_o is exactly 2 cycles when out_rdy_i is held high.
REQ-023 Throughput is one transaction per cycle when out_rdy_i = 1.
REQ-024 Advance conditions:
  - S2 accepts new data when ~s2_vld | out_rdy_i.
  - S1 advances into S2 under that same condition.
  - in_rdy_o = ~s1_vld | (~s2_vld | out_rdy_i).
  - in_rdy_o may depend combinationally on out_rdy_i.
REQ-025 A bubble in S2 is filled by S1 even while out_rdy_i = 0; no bubble is held while a downstream slot is free.
REQ-026 While out_vld_o = 1 and out_rdy_i = 0, all result outputs hold stable.
REQ-027 Results emerge in acceptance order; none is dropped or duplicated.
REQ-028 in_vld_i with in_rdy_o = 0 has no effect; the source must hold its request.
REQ-029 Statistics counters:
  - Each counter increments by 1 on each output handshake, according to that result's any_o.
  - Each counter saturates at 2^CNT_W - 1 and never wraps.
REQ-030 pos_i is taken modulo W by construction; all values are legal in every mode.
REQ-031 For x = 0, in all modes: any = 0, y = 0, y_enc = 0, rem = 0.

Reset
REQ-032 When rst = 1 at a rising edge of clk, the next state is:
  - s1_vld = 0, s2_vld = 0, out_vld_o = 0;
  - hit_cnt_o = 0, miss_cnt_o = 0.
REQ-033 Reset mid-operation discards all in-flight transactions; no result for them appears after reset.
REQ-034 in_rdy_o = 1 in the first cycle after rst deasserts.
REQ-035 Data registers (x, pos, tag, results) have no reset and are don't-care while the matching valid is 0.
REQ-036 No counter increments in a cycle with rst = 1.

Verification (W = 8, TAG_W = 4, out_rdy_i = 1 unless stated)
REQ-037 x = 0x12, pos = 2, mode 0, clr = 1, tag = 5 -> 2 cycles later:
  - any = 1, y = 0x10, y_enc = 4, rem = 0x02, tag = 5.
REQ-038 x = 0x12, pos = 5:
  - mode 1 -> any = 0, y = 0, y_enc = 0, rem = 0x12.
  - mode 0 -> any = 1, y_enc = 1.
REQ-039 x = 0x12, pos = 3:
  - mode 2 -> y_enc = 1.
  - mode 3 -> y_enc = 1.
  - pos = 0 with mode 3 -> any = 0.
  - pos = 0 with mode 2 -> y_enc = 4.
REQ-040 Back-to-back sends of tags 1, 2, 3, 4 with out_rdy_i = 0 for 5 cycles:
  - in_rdy_o falls after 2 acceptances.
  - After release, tags appear in order 1, 2, 3, 4 with stable outputs while stalled.
  - Exactly 4 handshakes occur.
REQ-041 rst pulsed 1 cycle while both stages are valid:
  - Next cycle: out_vld_o = 0, counters = 0, in_rdy_o = 1.
  - No stale result ever appears.
REQ-042 CNT_W = 2, 5 consumed hits -> hit_cnt_o = 3 (saturated), miss_cnt_o = 0.
